// File: rtl/src_rr_merge.sv
// ---------------------------------------------------------------------------
// src_rr_merge
//
// Purpose:
//   Merges a tagged input stream into one output stream. Each word carries a
//   source index and is buffered in a FIFO dedicated to that source. A
//   round-robin arbiter drains the FIFOs into a single output register.
//   Words from one source always leave in the order they arrived.
//
// Parameters:
//   DATA_W  - payload width
//   NUM_SRC - number of sources (2..16)
//   DEPTH   - entries per source FIFO (power of 2, >= 2)
//
// Ports:
//   clk       - sole clock, all state changes on its rising edge
//   reset     - synchronous, active-high; empties every FIFO and the output
//   in_valid  - an input word is present
//   in_src    - source index of the input word
//   in_data   - input payload
//   in_ready  - FIFO addressed by in_src has room (combinational,
//               independent of in_valid, 0 for an out-of-range index)
//   o_valid   - output register holds a word
//   o_src     - source index of the output word
//   o_data    - output payload
//   o_ready   - downstream takes the output word this cycle
//   fifo_full - registered per-source full flags
// ---------------------------------------------------------------------------
module src_rr_merge #(
    parameter  int DATA_W  = 8,
    parameter  int NUM_SRC = 4,
    parameter  int DEPTH   = 4,
    localparam int SRC_W   = $clog2(NUM_SRC)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    input  logic [SRC_W-1:0]   in_src,
    input  logic [DATA_W-1:0]  in_data,
    output logic               in_ready,
    output logic               o_valid,
    output logic [SRC_W-1:0]   o_src,
    output logic [DATA_W-1:0]  o_data,
    input  logic               o_ready,
    output logic [NUM_SRC-1:0] fifo_full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [NUM_SRC-1:0] full_q;
    logic [NUM_SRC-1:0] non_empty;
    logic [NUM_SRC-1:0] wr_en;
    logic [NUM_SRC-1:0] pop_en;
    logic [DATA_W-1:0]  head_data [NUM_SRC];

    logic               src_ok;
    logic [SRC_W-1:0]   last_grant;
    logic [SRC_W-1:0]   grant;
    logic [SRC_W-1:0]   cand;
    logic               grant_found;
    logic               load;
    int                 scan_idx;

    assign src_ok    = (int'(in_src) < NUM_SRC);
    assign fifo_full = full_q;

    // Input acceptance looks only at the registered full flags, so a full
    // FIFO refuses a word even in a cycle where it is also being popped.
    always_comb begin
        in_ready = 1'b0;
        if (src_ok) begin
            in_ready = !full_q[in_src];
        end
    end

    // Per-source FIFOs. Eligibility for grant comes from the registered
    // count, so a word written this cycle cannot be granted until the next.
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_fifo
        logic [DATA_W-1:0] mem [DEPTH];
        logic [PTR_W-1:0]  wr_ptr;
        logic [PTR_W-1:0]  rd_ptr;
        logic [CNT_W-1:0]  count;
        logic [CNT_W-1:0]  count_next;
        logic              full_r;

        assign wr_en[i]     = in_valid && in_ready && (in_src == SRC_W'(i));
        assign pop_en[i]    = load && (grant == SRC_W'(i));
        assign non_empty[i] = (count != '0);
        assign full_q[i]    = full_r;
        assign head_data[i] = mem[rd_ptr];

        // A simultaneous write and pop cancel out in the count.
        always_comb begin
            count_next = count + CNT_W'(wr_en[i]) - CNT_W'(pop_en[i]);
        end

        // Pointer, occupancy and full-flag registers; pointers wrap
        // naturally because DEPTH is a power of two.
        always_ff @(posedge clk) begin
            if (reset) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
                full_r <= 1'b0;
            end else begin
                if (wr_en[i]) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (pop_en[i]) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                count  <= count_next;
                full_r <= (count_next == CNT_W'(DEPTH));
            end
        end

        // Storage array is not reset; only the pointers define its content.
        always_ff @(posedge clk) begin
            if (!reset && wr_en[i]) begin
                mem[wr_ptr] <= in_data;
            end
        end
    end

    // Round-robin search: start one past the last granted source and take
    // the first non-empty FIFO, wrapping around the source range.
    always_comb begin
        grant       = '0;
        grant_found = 1'b0;
        scan_idx    = 0;
        cand        = '0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            scan_idx = (int'(last_grant) + k) % NUM_SRC;
            cand     = SRC_W'(scan_idx);
            if (!grant_found && non_empty[cand]) begin
                grant_found = 1'b1;
                grant       = cand;
            end
        end
    end

    // The output register takes a new word whenever it is empty or being
    // drained, and some FIFO has data; the granted FIFO pops in the same
    // cycle.
    assign load = (!o_valid || o_ready) && grant_found;

    // Output register and round-robin pointer. Without a load, a drained
    // word clears o_valid while o_src/o_data keep their last value.
    always_ff @(posedge clk) begin
        if (reset) begin
            o_valid    <= 1'b0;
            o_src      <= '0;
            o_data     <= '0;
            last_grant <= SRC_W'(NUM_SRC - 1);
        end else if (load) begin
            o_valid    <= 1'b1;
            o_src      <= grant;
            o_data     <= head_data[grant];
            last_grant <= grant;
        end else if (o_ready) begin
            o_valid    <= 1'b0;
        end
    end

endmodule

// File: doc/src_rr_merge.md
SRC_RR_MERGE -- requirements
Module: src_rr_merge

Interface
REQ-001 SHALL have parameter DATA_W, default 8, input/output data width.
REQ-002 SHALL have parameter NUM_SRC, default 4, number of sources (2..16).
REQ-003 SHALL have parameter DEPTH, default 4, per-source FIFO entries (power of 2, >=2).
REQ-004 SHALL derive SRC_W = $clog2(NUM_SRC) locally.
REQ-005 clk  input  1  sole clock; all state updates on posedge clk.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 in_valid  input  1  input word present.
REQ-008 in_src  input  SRC_W  source index of input word.
REQ-009 in_data  input  DATA_W  input payload.
REQ-010 in_ready  output  1  FIFO selected by in_src can accept a word.
REQ-011 o_valid  output  1  output word present.
REQ-012 o_src  output  SRC_W  source index of output word.
REQ-013 o_data  output  DATA_W  output payload.
REQ-014 o_ready  input  1  downstream accepts the output word.
REQ-015 fifo_full  output  NUM_SRC  per-source FIFO full flags.

Function
REQ-016 SHALL contain NUM_SRC independent FIFOs, each DEPTH x DATA_W, with wrap-around read/write pointers and an occupancy counter of width $clog2(DEPTH)+1.
REQ-017 in_ready SHALL be combinational: !full[in_src]; in_ready is independent of in_valid.
REQ-018 A word SHALL be written to FIFO[in_src] on a clock edge where in_valid && in_ready; otherwise no write occurs.
REQ-019 in_src >= NUM_SRC SHALL give in_ready=0 and nothing written.
REQ-020 fifo_full[i] SHALL equal (count[i]==DEPTH), registered.
REQ-021 The output stage SHALL be a single register holding o_valid/o_src/o_data.
REQ-022 The output register SHALL load when (!o_valid || o_ready) and at least one FIFO is non-empty; otherwise o_valid clears on o_ready, or holds.
REQ-023 While o_valid && !o_ready, o_src and o_data SHALL stay stable.
REQ-024 Arbitration SHALL be round-robin: grant the first non-empty FIFO searching from (last_grant+1) mod NUM_SRC upward with wrap; last_grant updates only on a load.
REQ-025 The granted FIFO SHALL be popped in the same cycle the output register loads; o_src SHALL equal the granted index.
REQ-026 Latency: word accepted at edge N into empty FIFO, with output register free and no competitors, SHALL appear with o_valid=1 after edge N+1.
REQ-027 A write and a pop of the same FIFO in one cycle SHALL both take effect; count unchanged.
REQ-028 A full FIFO SHALL not accept a write even if popped that cycle (in_ready uses pre-pop state).
REQ-029 A word written into an empty FIFO SHALL not be eligible for grant in its write cycle.
REQ-030 Per-source ordering SHALL be preserved; no word shall be dropped or duplicated.
REQ-031 With back-to-back o_ready=1 and all FIFOs non-empty, throughput SHALL be one word per cycle, sources cycling in index order.

Reset
REQ-032 While reset=1: all FIFOs empty, pointers and counts 0, o_valid=0, o_src=0, o_data=0, fifo_full=0, last_grant=NUM_SRC-1 (source 0 has first priority).
REQ-033 Reset asserted mid-operation SHALL discard all buffered and output-register content at the next edge; in_ready SHALL reflect the empty state on the cycle after.
REQ-034 No writes or output loads SHALL occur on an edge where reset=1.

Verification
REQ-035 Single word: in_src=2, in_data=8'hA5 accepted at edge N, o_ready=1 -> o_valid=1, o_src=2, o_data=A5 after edge N+1, o_valid=0 the cycle after.
REQ-036 Fill: 4 writes to src 1 with o_ready=0 -> fifo_full[1]=1, in_ready=0 for in_src=1, in_ready=1 for in_src=0; fifth word not stored.
REQ-037 Round-robin: preload src0={10,11}, src1={20}, src3={30}, o_ready=1 -> output order 10,20,30,11 with o_src 0,1,3,0.
REQ-038 Backpressure: o_valid=1, o_ready=0 for 5 cycles -> o_data/o_src unchanged; on o_ready=1 next word follows in the next cycle.
REQ-039 Reset mid-stream: 3 words buffered, reset pulsed 1 cycle -> o_valid=0, fifo_full=0, no buffered word ever emitted; next word emits with o_src per REQ-032 priority.
REQ-040 Random: NUM_SRC=4, DEPTH=8, random in_valid/in_src/o_ready for 10k cycles -> scoreboard per-source in-order match, no loss, no stall while any FIFO non-empty and o_ready=1.
